ibex_avalon_responder: RTL and testbench
========================================

Name: ibex_avalon_responder

Overview:
- Memory-side responder for the Ibex instruction or data request interface (req/gnt/rvalid, initiated by ibex_core).
- Translates each granted request into an Avalon-MM access on the on-chip memory (fixed read latency, waitrequest-capable).
- Returns in-order rvalid/rdata/err to the core.
- Requests outside [MemStart, MemStart+MemSize) never reach Avalon; they complete with err_o=1.

Parameters:
- MemStart, 32'h0000_0000, byte base address of the memory window.
- MemSize, 65536, window size in bytes; power of two, at least 4.
- ReadLatency, 1, fixed Avalon read latency in cycles; legal range 1..4.
- AddrWidth, $clog2(MemSize/4), Avalon word-address width; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  core request; addr/we/be/wdata stable while req_i=1 and gnt_o=0.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid, one per granted request.
- we_i  in  1  1=write.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address; bits [1:0] ignored.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data.
- err_o  out  1  response error; qualified by rvalid_o.
- avm_address_o  out  AddrWidth  word address, (addr-MemStart)>>2.
- avm_read_o  out  1  Avalon read strobe.
- avm_write_o  out  1  Avalon write strobe.
- avm_chipselect_o  out  1  avm_read_o|avm_write_o.
- avm_byteenable_o  out  4  be for writes; 4'hF for reads.
- avm_writedata_o  out  32  write data.
- avm_readdata_i  in  32  read data, valid ReadLatency cycles after read acceptance.
- avm_waitrequest_i  in  1  Avalon stall.

Behaviour:
- Reset: all outputs 0; command register empty; response pipeline empty.
- Command register holds one transaction: cmd_valid, cmd_we, cmd_err, addr, be, wdata. All avm_* outputs are driven from it only, so they are registered.
- in_range = ((addr_i - MemStart) & ~(MemSize-1)) == 0; cmd_err = !in_range.
- Command leaves the register (cmd_fire) when cmd_valid && (cmd_err || !avm_waitrequest_i).
- Strobes: avm_read_o = cmd_valid & !cmd_err & !cmd_we; avm_write_o = cmd_valid & !cmd_err & cmd_we. Both held unchanged while avm_waitrequest_i=1.
- gnt_o = req_i && (!cmd_valid || cmd_fire). Combinational, so a grant can land in the same cycle as the request.
- On grant, the command register loads the core request. Simultaneous cmd_fire and grant replaces the entry, giving back-to-back throughput of 1 per cycle.
- Response pipeline: ReadLatency-stage shift register of {valid, we, err}; stage 0 is loaded with cmd_fire.
- rvalid_o is asserted exactly ReadLatency cycles after cmd_fire, for reads, writes and errors alike. Responses are therefore strictly in order and never collide.
- Response output: err_o = entry.err. rdata_o = avm_readdata_i for a successful read, 32'h0 otherwise.
- Maximum outstanding: 1 in the command register plus ReadLatency in the pipeline. No backpressure on responses.
- Write with be=0 is issued to Avalon unchanged.
- Reset asserted mid-operation: the in-flight command and all pending responses are dropped, with no rvalid. Avalon strobes drop asynchronously.

Decomposition:
- Package ibex_avalon_pkg holds:
  - resp_t (valid, we, err);
  - cmd_t (we, err, addr, be, wdata);
  - constants MaxReadLatency=4 and MinMemSize=4.
- Sub-module ibex_avalon_resp_pipe: a parameterised ReadLatency-deep shift register of resp_t with async active-high reset.

Test Plan:
- Read at addr 0x10, ReadLatency=1, memory word 4 = 0xDEADBEEF -> same-cycle gnt; avm_read_o with address 4 next cycle; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 two cycles after req.
- Four back-to-back reads at 0x0, 0x4, 0x8, 0xC, no waitrequest -> gnt on 4 consecutive cycles; 4 consecutive rvalid with data in order.
- Write 0x12345678 with be=4'b0011 to 0x20 while waitrequest is high for 3 cycles -> avm_write_o and avm_byteenable_o=0011 stable for 4 cycles; second request not granted until the write fires; rvalid ReadLatency cycles after the fire.
- Read at 0x0001_0000 (out of range) -> no Avalon strobe; rvalid_o with err_o=1 and rdata_o=0 ReadLatency cycles after the fire.
- ReadLatency=3, sequence read/write/read/error -> four rvalids in issue order; read data matches the memory model; the write lands before the following read.
- Reset pulse with 2 reads in flight -> no rvalid after reset; avm strobes 0; the next request completes normally.

Source files
------------

// File: rtl/ibex_avalon_pkg.sv
// Shared types and limits for the Ibex request/grant to Avalon-MM responder.
package ibex_avalon_pkg;

    localparam int MaxReadLatency = 4;
    localparam int MinMemSize     = 4;

    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ibex_avalon_resp_pipe.sv
// Fixed-depth response shift register; one stage per cycle of Avalon read latency.
module ibex_avalon_resp_pipe
    import ibex_avalon_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  resp_t i_resp,
    output resp_t o_resp
);

    resp_t r_stage [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: every stage is reset, not only valid, so a reset mid-flight can never emit a response.
            for (int i = 0; i < Depth; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_resp;
            for (int i = 1; i < Depth; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_resp = r_stage[Depth-1];

endmodule

// File: rtl/ibex_avalon_responder.sv
// Ibex req/gnt/rvalid responder driving an on-chip Avalon-MM memory with fixed read latency.
module ibex_avalon_responder
    import ibex_avalon_pkg::*;
#(
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter int          MemSize     = 65536,
    parameter int          ReadLatency = 1,
    parameter int          AddrWidth   = $clog2(MemSize / 4)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [AddrWidth-1:0] avm_address_o,
    output logic                 avm_read_o,
    output logic                 avm_write_o,
    output logic                 avm_chipselect_o,
    output logic [3:0]           avm_byteenable_o,
    output logic [31:0]          avm_writedata_o,
    input  logic [31:0]          avm_readdata_i,
    input  logic                 avm_waitrequest_i
);

    localparam int LatDepth = (ReadLatency < 1) ? 1 :
                              (ReadLatency > MaxReadLatency) ? MaxReadLatency : ReadLatency;
    localparam int          WinSize = (MemSize < MinMemSize) ? MinMemSize : MemSize;
    localparam logic [31:0] WinMask = 32'(WinSize - 1);

    logic        r_cmd_valid;
    cmd_t        r_cmd;
    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_cmd_fire;
    logic        w_issue;
    resp_t       w_resp_in;
    resp_t       w_resp_out;
    logic        w_unused;

    assign w_offset   = addr_i - MemStart;
    assign w_in_range = (w_offset & ~WinMask) == 32'h0;

    // Errored commands never touch Avalon, so they leave the register without waiting.
    assign w_cmd_fire = r_cmd_valid && (r_cmd.err || !avm_waitrequest_i);
    assign gnt_o      = req_i && !rst_i && (!r_cmd_valid || w_cmd_fire);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
        end else if (gnt_o) begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= '{we: we_i, err: !w_in_range, addr: w_offset, be: be_i, wdata: wdata_i};
        end else if (w_cmd_fire) begin
            r_cmd_valid <= 1'b0;
        end
    end

    assign w_issue          = r_cmd_valid && !r_cmd.err;
    assign avm_read_o       = w_issue && !r_cmd.we;
    assign avm_write_o      = w_issue && r_cmd.we;
    assign avm_chipselect_o = w_issue;
    assign avm_byteenable_o = avm_write_o ? r_cmd.be : (avm_read_o ? 4'hF : 4'h0);
    assign avm_address_o    = r_cmd.addr[AddrWidth+1:2];
    assign avm_writedata_o  = r_cmd.wdata;

    assign w_resp_in = '{valid: w_cmd_fire, we: r_cmd.we, err: r_cmd.err};

    ibex_avalon_resp_pipe #(
        .Depth (LatDepth)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_resp (w_resp_in),
        .o_resp (w_resp_out)
    );

    // Read data arrives on the bus in the same cycle its response entry leaves the pipe.
    assign rvalid_o = w_resp_out.valid;
    assign err_o    = w_resp_out.valid && w_resp_out.err;
    assign rdata_o  = (w_resp_out.valid && !w_resp_out.we && !w_resp_out.err) ? avm_readdata_i : 32'h0;

    assign w_unused = ^{r_cmd.addr[31:AddrWidth+2], r_cmd.addr[1:0]};

endmodule

// File: tb/tb_ibex_avalon_responder.sv
// Directed scoreboard bench: instance 0 uses ReadLatency=1, instance 1 uses ReadLatency=3.
module tb_ibex_avalon_responder;

    localparam int NInst = 2;
    localparam int AW    = 14;

    typedef struct {
        int          inst;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          req         [NInst];
    logic          gnt         [NInst];
    logic          rvalid      [NInst];
    logic          we          [NInst];
    logic [3:0]    be          [NInst];
    logic [31:0]   addr        [NInst];
    logic [31:0]   wdata       [NInst];
    logic [31:0]   rdata       [NInst];
    logic          err         [NInst];
    logic [AW-1:0] avm_address [NInst];
    logic          avm_read    [NInst];
    logic          avm_write   [NInst];
    logic          avm_cs      [NInst];
    logic [3:0]    avm_be      [NInst];
    logic [31:0]   avm_wdata   [NInst];
    logic [31:0]   avm_rdata   [NInst];
    logic          avm_wait    [NInst];

    logic [31:0] ref_mem [NInst][64];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h11;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NInst; k++) begin : g_inst
        localparam int Lat = (k == 0) ? 1 : 3;
        logic [31:0] mem     [64];
        logic [31:0] rd_pipe [Lat];

        ibex_avalon_responder #(
            .ReadLatency (Lat)
        ) u_dut (
            .clk_i             (clk),
            .rst_i             (rst),
            .req_i             (req[k]),
            .gnt_o             (gnt[k]),
            .rvalid_o          (rvalid[k]),
            .we_i              (we[k]),
            .be_i              (be[k]),
            .addr_i            (addr[k]),
            .wdata_i           (wdata[k]),
            .rdata_o           (rdata[k]),
            .err_o             (err[k]),
            .avm_address_o     (avm_address[k]),
            .avm_read_o        (avm_read[k]),
            .avm_write_o       (avm_write[k]),
            .avm_chipselect_o  (avm_cs[k]),
            .avm_byteenable_o  (avm_be[k]),
            .avm_writedata_o   (avm_wdata[k]),
            .avm_readdata_i    (avm_rdata[k]),
            .avm_waitrequest_i (avm_wait[k])
        );

        initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);

        // Avalon memory: accepted reads return data Lat cycles later, idle slots carry junk.
        always @(posedge clk) begin
            if (avm_write[k] && !avm_wait[k])
                for (int b = 0; b < 4; b++)
                    if (avm_be[k][b]) mem[avm_address[k][5:0]][8*b +: 8] <= avm_wdata[k][8*b +: 8];
            rd_pipe[0] <= (avm_read[k] && !avm_wait[k]) ? mem[avm_address[k][5:0]] : (32'hBAD0_0000 | 32'(k));
            for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
        end

        assign avm_rdata[k] = rd_pipe[Lat-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic to_cycle_start();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for its grant, and record the expected response.
    task automatic issue(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, output int waits);
        exp_t e;
        int   idx;
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        waits = 0;
        @(negedge clk);
        while (!gnt[k] && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        check("gnt_seen", 32'(gnt[k]), 32'd1);
        idx     = int'(a[7:2]);
        e.inst  = k;
        e.err   = (a >= 32'h0001_0000);
        e.rdata = 32'h0;
        if (!e.err && !w) e.rdata = ref_mem[k][idx];
        if (!e.err && w)
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[k][idx][8*i +: 8] = d[8*i +: 8];
        if (gnt[k]) exp_q.push_back(e);
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    task automatic monitor_step();
        exp_t e;
        for (int k = 0; k < NInst; k++) begin
            if (rvalid[k]) begin
                check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("resp_inst", 32'(k), 32'(e.inst));
                    check("resp_err", 32'(err[k]), 32'(e.err));
                    check("resp_rdata", rdata[k], e.rdata);
                end
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0, n1, n2, n3;
        rst = 1'b1;
        for (int k = 0; k < NInst; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
            avm_wait[k] = 1'b0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
        end
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < NInst; k++) begin
            check("rst_gnt", 32'(gnt[k]), 32'd0);
            check("rst_rvalid", 32'(rvalid[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_rdata", rdata[k], 32'd0);
            check("rst_avm_read", 32'(avm_read[k]), 32'd0);
            check("rst_avm_write", 32'(avm_write[k]), 32'd0);
            check("rst_avm_cs", 32'(avm_cs[k]), 32'd0);
            check("rst_avm_be", 32'(avm_be[k]), 32'd0);
            check("rst_avm_address", 32'(avm_address[k]), 32'd0);
            check("rst_avm_wdata", avm_wdata[k], 32'd0);
        end
        to_cycle_start();
        rst = 1'b0;
        repeat (2) to_cycle_start();

        // Single read at 0x10, latency 1
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, n);
        check("t1_gnt_wait", 32'(n), 32'd0);
        @(negedge clk);
        check("t1_avm_read", 32'(avm_read[0]), 32'd1);
        check("t1_avm_write", 32'(avm_write[0]), 32'd0);
        check("t1_avm_cs", 32'(avm_cs[0]), 32'd1);
        check("t1_avm_address", 32'(avm_address[0]), 32'd4);
        check("t1_avm_be", 32'(avm_be[0]), 32'hF);
        check("t1_rvalid_early", 32'(rvalid[0]), 32'd0);
        @(negedge clk);
        check("t1_rvalid", 32'(rvalid[0]), 32'd1);
        @(negedge clk);
        check("t1_rvalid_drop", 32'(rvalid[0]), 32'd0);
        to_cycle_start();

        // Four back-to-back reads
        fork
            begin
                issue(0, 1'b0, 4'hF, 32'h0, 32'h0, n0);
                issue(0, 1'b0, 4'hF, 32'h4, 32'h0, n1);
                issue(0, 1'b0, 4'hF, 32'h8, 32'h0, n2);
                issue(0, 1'b0, 4'hF, 32'hC, 32'h0, n3);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("t2_rvalid", 32'(rvalid[0]), 32'd1);
                end
                @(negedge clk);
                check("t2_rvalid_drop", 32'(rvalid[0]), 32'd0);
            end
        join
        check("t2_gnt_waits", 32'(n0 + n1 + n2 + n3), 32'd0);
        to_cycle_start();

        // Write held by waitrequest for 3 cycles, a read queued behind it
        avm_wait[0] = 1'b1;
        issue(0, 1'b1, 4'b0011, 32'h20, 32'h1234_5678, n);
        check("t3_wr_gnt_wait", 32'(n), 32'd0);
        fork
            issue(0, 1'b0, 4'hF, 32'h20, 32'h0, n1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("t3_avm_write", 32'(avm_write[0]), 32'd1);
                    check("t3_avm_be", 32'(avm_be[0]), 32'h3);
                    check("t3_avm_address", 32'(avm_address[0]), 32'd8);
                    check("t3_avm_wdata", avm_wdata[0], 32'h1234_5678);
                    check("t3_gnt_held", 32'(gnt[0]), 32'd0);
                    check("t3_rvalid_held", 32'(rvalid[0]), 32'd0);
                end
                to_cycle_start();
                avm_wait[0] = 1'b0;
                @(negedge clk);
                check("t3_avm_write_fire", 32'(avm_write[0]), 32'd1);
                check("t3_gnt_on_fire", 32'(gnt[0]), 32'd1);
                check("t3_rvalid_before", 32'(rvalid[0]), 32'd0);
            end
        join
        check("t3_rd_gnt_wait", 32'(n1), 32'd3);
        @(negedge clk);
        check("t3_wr_rvalid", 32'(rvalid[0]), 32'd1);
        @(negedge clk);
        check("t3_rd_rvalid", 32'(rvalid[0]), 32'd1);
        to_cycle_start();

        // Out-of-range read
        issue(0, 1'b0, 4'hF, 32'h0001_0000, 32'h0, n);
        check("t4_gnt_wait", 32'(n), 32'd0);
        @(negedge clk);
        check("t4_avm_read", 32'(avm_read[0]), 32'd0);
        check("t4_avm_write", 32'(avm_write[0]), 32'd0);
        check("t4_avm_cs", 32'(avm_cs[0]), 32'd0);
        @(negedge clk);
        check("t4_rvalid", 32'(rvalid[0]), 32'd1);
        check("t4_err", 32'(err[0]), 32'd1);
        to_cycle_start();

        // Latency 3: read / write / read / error, back to back
        fork
            begin
                issue(1, 1'b0, 4'hF, 32'h8, 32'h0, n0);
                issue(1, 1'b1, 4'b1100, 32'h8, 32'hCAFE_F00D, n1);
                issue(1, 1'b0, 4'hF, 32'h8, 32'h0, n2);
                issue(1, 1'b0, 4'hF, 32'h0002_0000, 32'h0, n3);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("t5_rvalid_idle", 32'(rvalid[1]), 32'd0);
                end
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("t5_rvalid", 32'(rvalid[1]), 32'd1);
                end
                @(negedge clk);
                check("t5_rvalid_drop", 32'(rvalid[1]), 32'd0);
            end
        join
        check("t5_gnt_waits", 32'(n0 + n1 + n2 + n3), 32'd0);
        to_cycle_start();

        // Reset with two reads in flight
        issue(1, 1'b0, 4'hF, 32'h30, 32'h0, n0);
        issue(1, 1'b0, 4'hF, 32'h34, 32'h0, n1);
        check("t6_avm_read_before", 32'(avm_read[1]), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_avm_read_async", 32'(avm_read[1]), 32'd0);
        check("t6_avm_cs_async", 32'(avm_cs[1]), 32'd0);
        @(negedge clk);
        check("t6_rvalid_in_rst", 32'(rvalid[1]), 32'd0);
        to_cycle_start();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_rvalid_dropped", 32'(rvalid[1]), 32'd0);
        end
        to_cycle_start();
        issue(1, 1'b0, 4'hF, 32'h3C, 32'h0, n);
        check("t6_gnt_wait", 32'(n), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_rvalid_wait", 32'(rvalid[1]), 32'd0);
        end
        @(negedge clk);
        check("t6_rvalid", 32'(rvalid[1]), 32'd1);

        repeat (8) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
